// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative, write-back, write-allocate cache controller.
// Sequences tag lookup, victim writeback and line fill between the CPU port,
// the external tag/data RAMs (synchronous read) and a 128-bit memory channel.
module cache_ctrl_2way #(
  parameter int NUMBER_OF_SETS   = 1000,
  parameter int INDEX_BIT        = 10,
  parameter int TAG_BIT          = 23,
  parameter int BLOCK_SIZE_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cpu_req_valid,
  output logic                              cpu_req_ready,
  input  logic                              cpu_req_rw,
  input  logic [31:0]                       cpu_req_addr,
  input  logic [31:0]                       cpu_req_wdata,
  output logic                              cpu_resp_valid,
  output logic [31:0]                       cpu_resp_rdata,
  output logic [INDEX_BIT-1:0]              ram_index,
  output logic                              tag0_we,
  output logic                              tag1_we,
  output logic [TAG_BIT-1:0]                tag_wdata0,
  output logic [TAG_BIT-1:0]                tag_wdata1,
  input  logic [TAG_BIT-1:0]                tag_rdata0,
  input  logic [TAG_BIT-1:0]                tag_rdata1,
  output logic                              db0_we,
  output logic                              db1_we,
  output logic [32*BLOCK_SIZE_WORDS-1:0]    db_wdata,
  input  logic [32*BLOCK_SIZE_WORDS-1:0]    db_rdata0,
  input  logic [32*BLOCK_SIZE_WORDS-1:0]    db_rdata1,
  output logic                              mem_req_valid,
  output logic                              mem_req_rw,
  output logic [31:0]                       mem_req_addr,
  output logic [32*BLOCK_SIZE_WORDS-1:0]    mem_wdata,
  input  logic                              mem_ready,
  input  logic [32*BLOCK_SIZE_WORDS-1:0]    mem_rdata
);

  localparam int LINE_BIT  = 32 * BLOCK_SIZE_WORDS;
  localparam int WSEL_BIT  = $clog2(BLOCK_SIZE_WORDS);
  localparam int OFF_BIT   = WSEL_BIT + 2;
  localparam int BLK_BIT   = 32 - OFF_BIT;
  localparam int TAG_FIELD = TAG_BIT - 3;
  localparam int V_BIT     = TAG_BIT - 1;
  localparam int D_BIT     = TAG_BIT - 2;
  localparam int U_BIT     = TAG_BIT - 3;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_ALLOCATE, S_RESPOND} state_t;

  state_t                state;
  logic                  rw_q;
  logic [31:0]           wdata_q;
  logic [WSEL_BIT-1:0]   sel_q;
  logic [INDEX_BIT-1:0]  idx_q;
  logic [TAG_FIELD-1:0]  tag_q;
  logic [31:0]           line_addr_q;
  logic                  way_q;
  logic [TAG_BIT-1:0]    other_ent_q;

  logic [BLK_BIT-1:0]    req_blk;
  logic [INDEX_BIT-1:0]  req_index;
  logic [TAG_FIELD-1:0]  req_tag;
  logic                  unused_addr_bits;

  logic                  hit0, hit1, hit, sel_way;
  logic [TAG_BIT-1:0]    sel_ent, oth_ent;
  logic [LINE_BIT-1:0]   sel_line;
  logic [31:0]           wb_addr;

  logic                  go_respond, fin_way, fin_dirty;
  logic [LINE_BIT-1:0]   fin_src, fin_line;
  logic [31:0]           fin_word;
  logic [TAG_BIT-1:0]    fin_ent, fin_other, fin_other_raw;

  function automatic logic [LINE_BIT-1:0] merge_word(input logic [LINE_BIT-1:0] line,
                                                     input logic [WSEL_BIT-1:0] sel,
                                                     input logic [31:0] word);
    logic [LINE_BIT-1:0] m;
    m = line;
    m[(BLOCK_SIZE_WORDS-1-int'(sel))*32 +: 32] = word;
    return m;
  endfunction

  function automatic logic [31:0] pick_word(input logic [LINE_BIT-1:0] line,
                                            input logic [WSEL_BIT-1:0] sel);
    return line[(BLOCK_SIZE_WORDS-1-int'(sel))*32 +: 32];
  endfunction

  // Block number, set index and tag of the incoming CPU address.
  assign req_blk          = cpu_req_addr[31:OFF_BIT];
  assign req_index        = INDEX_BIT'(req_blk % BLK_BIT'(NUMBER_OF_SETS));
  assign req_tag          = TAG_FIELD'(req_blk / BLK_BIT'(NUMBER_OF_SETS));
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign cpu_req_ready = (state == S_IDLE);

  // The index is presented combinationally while a request waits in IDLE so the
  // synchronous RAMs return the set during LOOKUP; afterwards the captured index holds.
  assign ram_index = (state == S_IDLE && cpu_req_valid) ? req_index : idx_q;

  // Tag compare and way selection: hit way, else invalid way, else used=0 way, else way0.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    hit0 = tag_rdata0[V_BIT] && (tag_rdata0[TAG_FIELD-1:0] == tag_q);
    hit1 = tag_rdata1[V_BIT] && (tag_rdata1[TAG_FIELD-1:0] == tag_q);
    hit  = hit0 || hit1;
    if (hit0)                    sel_way = 1'b0;
    else if (hit1)               sel_way = 1'b1;
    else if (!tag_rdata0[V_BIT]) sel_way = 1'b0;
    else if (!tag_rdata1[V_BIT]) sel_way = 1'b1;
    else if (!tag_rdata0[U_BIT]) sel_way = 1'b0;
    else if (!tag_rdata1[U_BIT]) sel_way = 1'b1;
    else                         sel_way = 1'b0;
    sel_ent  = sel_way ? tag_rdata1 : tag_rdata0;
    oth_ent  = sel_way ? tag_rdata0 : tag_rdata1;
    sel_line = sel_way ? db_rdata1  : db_rdata0;
    wb_addr  = {BLK_BIT'(32'(sel_ent[TAG_FIELD-1:0]) * 32'(NUMBER_OF_SETS) + 32'(idx_q)),
                {OFF_BIT{1'b0}}};
  end

  // Line, tag entries and response word written on entry to RESPOND (hit or fill).
  always_comb begin
    go_respond    = (state == S_LOOKUP && hit) ||
                    (state == S_ALLOCATE && mem_req_valid && mem_ready);
    fin_src       = (state == S_LOOKUP) ? sel_line : mem_rdata;
    fin_way       = (state == S_LOOKUP) ? sel_way  : way_q;
    fin_dirty     = rw_q || ((state == S_LOOKUP) && sel_ent[D_BIT]);
    fin_line      = rw_q ? merge_word(fin_src, sel_q, wdata_q) : fin_src;
    fin_word      = pick_word(fin_line, sel_q);
    fin_ent       = {1'b1, fin_dirty, 1'b1, tag_q};
    fin_other_raw = (state == S_LOOKUP) ? oth_ent : other_ent_q;
    fin_other     = fin_other_raw;
    fin_other[U_BIT] = 1'b0;
  end

  // Controller FSM with registered CPU, RAM and memory-channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rw_q           <= 1'b0;
      wdata_q        <= '0;
      sel_q          <= '0;
      idx_q          <= '0;
      tag_q          <= '0;
      line_addr_q    <= '0;
      way_q          <= 1'b0;
      other_ent_q    <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      tag0_we        <= 1'b0;
      tag1_we        <= 1'b0;
      tag_wdata0     <= '0;
      tag_wdata1     <= '0;
      db0_we         <= 1'b0;
      db1_we         <= 1'b0;
      db_wdata       <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_wdata      <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            rw_q        <= cpu_req_rw;
            wdata_q     <= cpu_req_wdata;
            sel_q       <= cpu_req_addr[OFF_BIT-1:2];
            idx_q       <= req_index;
            tag_q       <= req_tag;
            line_addr_q <= {cpu_req_addr[31:OFF_BIT], {OFF_BIT{1'b0}}};
            state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          way_q       <= sel_way;
          other_ent_q <= oth_ent;
          if (hit) begin
            state <= S_RESPOND;
          end else if (sel_ent[V_BIT] && sel_ent[D_BIT]) begin
            mem_req_valid <= 1'b1;
            mem_req_rw    <= 1'b1;
            mem_req_addr  <= wb_addr;
            mem_wdata     <= sel_line;
            state         <= S_WRITEBACK;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= line_addr_q;
            state         <= S_ALLOCATE;
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= line_addr_q;
          end else if (mem_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          cpu_resp_valid <= 1'b0;
          tag0_we        <= 1'b0;
          tag1_we        <= 1'b0;
          db0_we         <= 1'b0;
          db1_we         <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (go_respond) begin
        cpu_resp_valid <= 1'b1;
        cpu_resp_rdata <= fin_word;
        db_wdata       <= fin_line;
        db0_we         <= ~fin_way;
        db1_we         <= fin_way;
        tag0_we        <= 1'b1;
        tag1_we        <= 1'b1;
        tag_wdata0     <= fin_way ? fin_other : fin_ent;
        tag_wdata1     <= fin_way ? fin_ent   : fin_other;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way: synchronous-read RAM models, a
// task-driven memory responder and a queue of expected CPU response words.
module tb_cache_ctrl_2way;

  logic         clk;
  logic         rst_n;
  logic         cpu_req_valid, cpu_req_ready, cpu_req_rw;
  logic [31:0]  cpu_req_addr, cpu_req_wdata;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic [9:0]   ram_index;
  logic         tag0_we, tag1_we, db0_we, db1_we;
  logic [22:0]  tag_wdata0, tag_wdata1, tag_rdata0, tag_rdata1;
  logic [127:0] db_wdata, db_rdata0, db_rdata1;
  logic         mem_req_valid, mem_req_rw, mem_ready;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_wdata, mem_rdata;

  // Backdoor preload port into the RAM models.
  logic         pre_we;
  logic [9:0]   pre_idx;
  logic [22:0]  pre_tag0, pre_tag1;
  logic [127:0] pre_db0, pre_db1;

  logic [22:0]  tag0_mem [1024] = '{default: '0};
  logic [22:0]  tag1_mem [1024] = '{default: '0};
  logic [127:0] db0_mem  [1024] = '{default: '0};
  logic [127:0] db1_mem  [1024] = '{default: '0};
  int           ram_wr_cnt = 0;

  logic [31:0]  exp_q [$];
  int           compared = 0;
  int           mismatched = 0;

  localparam logic [31:0]  WA = 32'hAAAA_0001, WB = 32'hBBBB_0002;
  localparam logic [31:0]  WC = 32'hCCCC_0003, WD = 32'hDDDD_0004;
  localparam logic [127:0] LINE_ABCD = {WA, WB, WC, WD};
  localparam logic [127:0] LINE_W0   = 128'h0101_0101_0202_0202_0303_0303_0404_0404;
  localparam logic [127:0] LINE_W1   = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
  localparam logic [127:0] LINE_F    = 128'hF000_0001_F000_0002_F000_0003_F000_0004;
  localparam logic [127:0] LINE_G    = 128'h6000_0001_6000_0002_6000_0003_6000_0004;

  cache_ctrl_2way dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .ram_index(ram_index),
    .tag0_we(tag0_we), .tag1_we(tag1_we), .tag_wdata0(tag_wdata0), .tag_wdata1(tag_wdata1),
    .tag_rdata0(tag_rdata0), .tag_rdata1(tag_rdata1),
    .db0_we(db0_we), .db1_we(db1_we), .db_wdata(db_wdata),
    .db_rdata0(db_rdata0), .db_rdata1(db_rdata1),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAMs: read returns the old contents, writes land on the edge.
  always @(posedge clk) begin
    tag_rdata0 <= tag0_mem[ram_index];
    tag_rdata1 <= tag1_mem[ram_index];
    db_rdata0  <= db0_mem[ram_index];
    db_rdata1  <= db1_mem[ram_index];
    if (tag0_we) tag0_mem[ram_index] <= tag_wdata0;
    if (tag1_we) tag1_mem[ram_index] <= tag_wdata1;
    if (db0_we)  db0_mem[ram_index]  <= db_wdata;
    if (db1_we)  db1_mem[ram_index]  <= db_wdata;
    if (tag0_we || tag1_we || db0_we || db1_we) ram_wr_cnt <= ram_wr_cnt + 1;
    if (pre_we) begin
      tag0_mem[pre_idx] <= pre_tag0;
      tag1_mem[pre_idx] <= pre_tag1;
      db0_mem[pre_idx]  <= pre_db0;
      db1_mem[pre_idx]  <= pre_db1;
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [22:0] t0, input logic [22:0] t1,
                         input logic [127:0] d0, input logic [127:0] d1);
    pre_idx = idx; pre_tag0 = t0; pre_tag1 = t1; pre_db0 = d0; pre_db1 = d1; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Presents one request in IDLE; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                      output bit ok);
    int n = 0;
    while (!cpu_req_ready && n < 100) begin @(negedge clk); n++; end
    ok = cpu_req_ready;
    if (!ok) return;
    cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  // Waits for a memory request, records it, then completes it after 'delay' cycles.
  task automatic serve_mem(input int delay, input logic [127:0] rdata, output bit ok,
                           output logic rw, output logic [31:0] addr, output logic [127:0] wd);
    int n = 0;
    while (!mem_req_valid && n < 100) begin @(negedge clk); n++; end
    ok = mem_req_valid; rw = mem_req_rw; addr = mem_req_addr; wd = mem_wdata;
    if (!ok) return;
    repeat (delay) @(negedge clk);
    mem_rdata = rdata; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic wait_resp(output bit ok, output logic [31:0] rdata);
    int n = 0;
    while (!cpu_resp_valid && n < 100) begin @(negedge clk); n++; end
    ok = cpu_resp_valid; rdata = cpu_resp_rdata;
  endtask

  // Pops the scoreboard and compares against the observed response word.
  task automatic score_resp(input string name);
    bit ok; logic [31:0] got, e;
    wait_resp(ok, got);
    compared++;
    if (!ok || exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: response seen=%0b, expected entries=%0d", name, ok, exp_q.size());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        mismatched++;
        $display("FAIL %s: rdata got %h, required %h", name, got, e);
      end
    end
  endtask

  task automatic test_reset;
    compared++;
    if ({cpu_resp_valid, mem_req_valid, mem_req_rw, tag0_we, tag1_we, db0_we, db1_we} !== 7'b0 ||
        mem_req_addr !== 32'h0 || ram_index !== 10'h0 || tag_wdata0 !== 23'h0 ||
        db_wdata !== 128'h0 || cpu_resp_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: resp_v=%b mem_v=%b addr=%h idx=%h tagw0=%h", cpu_resp_valid,
               mem_req_valid, mem_req_addr, ram_index, tag_wdata0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (cpu_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b, required 1", cpu_req_ready);
    end
  endtask

  task automatic test_miss_clean;
    bit ok; logic rw; logic [31:0] a; logic [127:0] wd;
    preload(10'd1, 23'h000000, 23'h100000, 128'h0, 128'h0);
    exp_q.push_back(WA);
    send(32'h0000_0010, 1'b0, 32'h0, ok);
    serve_mem(0, LINE_ABCD, ok, rw, a, wd);
    compared++;
    if (!ok || rw !== 1'b0 || a !== 32'h0000_0010) begin
      mismatched++;
      $display("FAIL miss_fill_req: seen=%0b rw=%b addr=%h, required rw=0 addr=00000010", ok, rw, a);
    end
    compared++;
    if (cpu_resp_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL miss_resp_latency: resp_valid=%b one cycle after mem_ready, required 1", cpu_resp_valid);
    end
    score_resp("miss_rdata");
    @(negedge clk);
    compared++;
    if (tag0_mem[1] !== 23'h500000 || tag1_mem[1] !== 23'h000000 || db0_mem[1] !== LINE_ABCD) begin
      mismatched++;
      $display("FAIL miss_ram_update: tag0=%h tag1=%h db0=%h, required 500000 000000 %h",
               tag0_mem[1], tag1_mem[1], db0_mem[1], LINE_ABCD);
    end
  endtask

  task automatic test_hit_load;
    bit ok; int memv = 0; logic resp_t2;
    exp_q.push_back(WD);
    send(32'h0000_001C, 1'b0, 32'h0, ok);
    if (mem_req_valid) memv++;
    @(negedge clk);
    resp_t2 = cpu_resp_valid;
    if (mem_req_valid) memv++;
    compared++;
    if (resp_t2 !== 1'b1) begin
      mismatched++;
      $display("FAIL hit_latency: resp_valid at T+2 = %b, required 1", resp_t2);
    end
    score_resp("hit_rdata");
    @(negedge clk);
    if (mem_req_valid) memv++;
    compared++;
    if (cpu_req_ready !== 1'b1 || memv != 0) begin
      mismatched++;
      $display("FAIL hit_turnaround: ready at T+3=%b mem_valid cycles=%0d, required 1 and 0", cpu_req_ready, memv);
    end
  endtask

  task automatic test_store_hit;
    bit ok;
    exp_q.push_back(32'hDEAD_BEEF);
    send(32'h0000_0014, 1'b1, 32'hDEAD_BEEF, ok);
    score_resp("store_rdata");
    @(negedge clk);
    compared++;
    if (db0_mem[1] !== {WA, 32'hDEAD_BEEF, WC, WD} || tag0_mem[1] !== 23'h700000 ||
        tag1_mem[1] !== 23'h000000) begin
      mismatched++;
      $display("FAIL store_ram_update: db0=%h tag0=%h tag1=%h, required %h 700000 000000",
               db0_mem[1], tag0_mem[1], tag1_mem[1], {WA, 32'hDEAD_BEEF, WC, WD});
    end
  endtask

  task automatic test_dirty_writeback;
    bit ok; logic rw; logic [31:0] a; logic [127:0] wd;
    preload(10'd1, 23'h600005, 23'h500006, LINE_W0, LINE_W1);
    exp_q.push_back(32'hF000_0001);
    send(32'h0001_B590, 1'b0, 32'h0, ok);
    serve_mem(1, 128'h0, ok, rw, a, wd);
    compared++;
    if (!ok || rw !== 1'b1 || a !== 32'h0001_3890 || wd !== LINE_W0) begin
      mismatched++;
      $display("FAIL wb_req: seen=%0b rw=%b addr=%h wdata=%h, required rw=1 addr=00013890 wdata=%h",
               ok, rw, a, wd, LINE_W0);
    end
    compared++;
    if (mem_req_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL wb_gap: mem_req_valid after writeback handshake=%b, required 0", mem_req_valid);
    end
    serve_mem(2, LINE_F, ok, rw, a, wd);
    compared++;
    if (!ok || rw !== 1'b0 || a !== 32'h0001_B590) begin
      mismatched++;
      $display("FAIL wb_fill_req: seen=%0b rw=%b addr=%h, required rw=0 addr=0001b590", ok, rw, a);
    end
    score_resp("wb_rdata");
    @(negedge clk);
    compared++;
    if (tag0_mem[1] !== 23'h500007 || tag1_mem[1] !== 23'h400006 || db0_mem[1] !== LINE_F ||
        db1_mem[1] !== LINE_W1) begin
      mismatched++;
      $display("FAIL wb_ram_update: tag0=%h tag1=%h db0=%h db1=%h, required 500007 400006",
               tag0_mem[1], tag1_mem[1], db0_mem[1], db1_mem[1]);
    end
  endtask

  task automatic test_stall;
    bit ok; int bad = 0; int extra = 0; int n = 0;
    exp_q.push_back(32'h6000_0001);
    send(32'h0000_0200, 1'b0, 32'h0, ok);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_001C;
    while (!mem_req_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 20; i++) begin
      if (cpu_req_ready !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0 ||
          mem_req_addr !== 32'h0000_0200 || ram_index !== 10'd32) bad++;
      @(negedge clk);
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL stall_stable: %0d of 20 stalled cycles showed ready/req/index changes, required 0", bad);
    end
    cpu_req_valid = 1'b0;
    mem_rdata = LINE_G; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    score_resp("stall_rdata");
    repeat (6) begin @(negedge clk); if (cpu_resp_valid) extra++; end
    compared++;
    if (extra != 0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL stall_no_second_accept: extra responses=%0d pending=%0d, required 0 0", extra, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_alloc;
    bit ok; int n = 0; int wr_before; logic memv_async;
    send(32'h0000_0300, 1'b0, 32'h0, ok);
    while (!mem_req_valid && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    wr_before = ram_wr_cnt;
    #2 rst_n = 1'b0;
    #1 memv_async = mem_req_valid;
    compared++;
    if (n >= 100 || memv_async !== 1'b0 || cpu_req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_abort: wait=%0d mem_req_valid=%b ready=%b, required valid 0 ready 1", n, memv_async, cpu_req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (ram_wr_cnt != wr_before || tag0_mem[48] !== 23'h0 || tag1_mem[48] !== 23'h0) begin
      mismatched++;
      $display("FAIL reset_no_write: writes=%0d (before %0d) tag0[48]=%h, required no change",
               ram_wr_cnt, wr_before, tag0_mem[48]);
    end
    exp_q.push_back(32'hF000_0004);
    send(32'h0001_B59C, 1'b0, 32'h0, ok);
    @(negedge clk);
    compared++;
    if (!ok || cpu_resp_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_hit: accepted=%0b resp_valid at T+2=%b, required 1 1", ok, cpu_resp_valid);
    end
    score_resp("post_reset_rdata");
  endtask

  initial begin
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_tag0 = '0; pre_tag1 = '0; pre_db0 = '0; pre_db1 = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_miss_clean;
    test_hit_load;
    test_store_hit;
    test_dirty_writeback;
    test_stall;
    test_reset_mid_alloc;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d expected responses never arrived, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
